// File: rtl/baud_tick_gen.sv
// Programmable baud tick generator: integer (+ optional fractional) clock divider
// producing oversample and bit ticks. Define BAUD_FRAC_EN to build the fractional accumulator.
module baud_tick_gen #(
    parameter int unsigned N        = 16,
    parameter int unsigned F        = 4,
    parameter int unsigned OVS      = 16,
    parameter int unsigned DEF_DIV  = 163,
    parameter int unsigned DEF_FRAC = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] div_int,
    input  logic [F-1:0] div_frac,
    input  logic         div_wr,
    output logic         div_pending,
    input  logic         sync_restart,
    output logic         s_tick,
    output logic         bit_tick
);

    localparam int unsigned OW = (OVS > 1) ? $clog2(OVS) : 1;

    logic [N-1:0]  divQ, divD;
    logic [N-1:0]  shDivQ, shDivD;
    logic          pendQ, pendD;
    logic [N-1:0]  cntQ, cntD;
    logic [OW-1:0] ovsQ, ovsD;
    logic          sTickQ, sTickD;
    logic          bitTickQ, bitTickD;
    logic          ext;
    logic          apply;
    logic          wrap;
    logic [N:0]    pLast;

`ifdef BAUD_FRAC_EN
    logic [F-1:0]  fracQ, fracD;
    logic [F-1:0]  shFracQ, shFracD;
    logic [F-1:0]  accQ, accD;
    logic          extQ, extD;
    logic [F:0]    fracSum;

    assign ext     = extQ;
    assign fracSum = {1'b0, accQ} + {1'b0, fracQ};
`else
    logic          unusedFrac;

    assign ext        = 1'b0;
    assign unusedFrac = ^{div_frac, F'(DEF_FRAC)};
`endif

    // N+1-bit compare so that D = 2^N-1 with an extended period does not overflow
    assign pLast = {1'b0, divQ} + {{N{1'b0}}, ext} - {{N{1'b0}}, 1'b1};
    assign wrap  = ({1'b0, cntQ} == pLast);

    always_comb begin
        cntD     = cntQ;
        ovsD     = ovsQ;
        sTickD   = 1'b0;
        bitTickD = 1'b0;
        apply    = 1'b0;
`ifdef BAUD_FRAC_EN
        accD     = accQ;
        extD     = extQ;
`endif
        if (sync_restart) begin
            cntD  = '0;
            ovsD  = '0;
            apply = 1'b1;
`ifdef BAUD_FRAC_EN
            accD  = '0;
            extD  = 1'b0;
`endif
        end else if (!en) begin
            apply = 1'b1;
        end else if (divQ == '0) begin
            cntD  = '0;
            apply = 1'b1;
        end else if (wrap) begin
            cntD     = '0;
            sTickD   = 1'b1;
            bitTickD = (ovsQ == OW'(OVS - 1));
            ovsD     = (ovsQ == OW'(OVS - 1)) ? '0 : ovsQ + OW'(1);
            apply    = 1'b1;
`ifdef BAUD_FRAC_EN
            accD     = fracSum[F-1:0];
            extD     = fracSum[F];
`endif
        end else begin
            cntD = cntQ + N'(1);
        end
    end

    // A write landing on an apply edge goes straight to the active divisor
    always_comb begin
        divD   = divQ;
        shDivD = div_wr ? div_int : shDivQ;
`ifdef BAUD_FRAC_EN
        fracD   = fracQ;
        shFracD = div_wr ? div_frac : shFracQ;
`endif
        if (apply) begin
            if (div_wr) begin
                divD = div_int;
`ifdef BAUD_FRAC_EN
                fracD = div_frac;
`endif
            end else if (pendQ) begin
                divD = shDivQ;
`ifdef BAUD_FRAC_EN
                fracD = shFracQ;
`endif
            end
        end
        pendD = div_wr ? !apply : (pendQ && !apply);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            divQ     <= N'(DEF_DIV);
            shDivQ   <= N'(DEF_DIV);
            pendQ    <= 1'b0;
            cntQ     <= '0;
            ovsQ     <= '0;
            sTickQ   <= 1'b0;
            bitTickQ <= 1'b0;
`ifdef BAUD_FRAC_EN
            fracQ    <= F'(DEF_FRAC);
            shFracQ  <= F'(DEF_FRAC);
            accQ     <= '0;
            extQ     <= 1'b0;
`endif
        end else begin
            divQ     <= divD;
            shDivQ   <= shDivD;
            pendQ    <= pendD;
            cntQ     <= cntD;
            ovsQ     <= ovsD;
            sTickQ   <= sTickD;
            bitTickQ <= bitTickD;
`ifdef BAUD_FRAC_EN
            fracQ    <= fracD;
            shFracQ  <= shFracD;
            accQ     <= accD;
            extQ     <= extD;
`endif
        end
    end

    assign div_pending = pendQ;
    assign s_tick      = sTickQ;
    assign bit_tick    = bitTickQ;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Self-checking bench for baud_tick_gen: directed scenarios plus randomized traffic,
// compared each cycle against a behavioural tick/period model.
module tb_baud_tick_gen;

    localparam int TN   = 16;
    localparam int TF   = 4;
    localparam int TOVS = 4;
    localparam int TDEF = 4;
`ifdef BAUD_FRAC_EN
    localparam bit FRAC_ON = 1'b1;
`else
    localparam bit FRAC_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic [TN-1:0] div_int = '0;
    logic [TF-1:0] div_frac = '0;
    logic          div_wr = 1'b0;
    logic          div_pending;
    logic          sync_restart = 1'b0;
    logic          s_tick;
    logic          bit_tick;

    int checks = 0;
    int errs = 0;
    int sCnt = 0;
    int bCnt = 0;

    // Reference model: current period position, fractional phase and tick count
    int mD, mFa, shD, shFa, mElapsed, mAcc, mExt, mTicks;
    bit mPend, expS, expB;

    bit rE, rSr, rWr;
    int rDi, rDf;

    baud_tick_gen #(
        .N(TN), .F(TF), .OVS(TOVS), .DEF_DIV(TDEF), .DEF_FRAC(0)
    ) dut (
        .clk(clk), .reset(reset), .en(en),
        .div_int(div_int), .div_frac(div_frac), .div_wr(div_wr),
        .div_pending(div_pending), .sync_restart(sync_restart),
        .s_tick(s_tick), .bit_tick(bit_tick)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mD = TDEF; mFa = 0; shD = TDEF; shFa = 0;
        mElapsed = 0; mAcc = 0; mExt = 0; mTicks = 0;
        mPend = 0; expS = 0; expB = 0;
    endtask

    task automatic modelStep(input bit e, input bit sr, input bit wr, input int di, input int df);
        bit ap;
        int sum;
        int dfe;
        ap = 0;
        dfe = FRAC_ON ? df : 0;
        expS = 0;
        expB = 0;
        if (sr) begin
            mElapsed = 0; mAcc = 0; mExt = 0; mTicks = 0; ap = 1;
        end else if (!e) begin
            ap = 1;
        end else if (mD == 0) begin
            mElapsed = 0; ap = 1;
        end else if (mElapsed == mD + mExt - 1) begin
            mElapsed = 0;
            expS = 1;
            sum = mAcc + mFa;
            mExt = sum / (1 << TF);
            mAcc = sum % (1 << TF);
            mTicks = (mTicks + 1) % TOVS;
            expB = (mTicks == 0);
            ap = 1;
        end else begin
            mElapsed = (mElapsed + 1) % (1 << TN);
        end
        if (ap) begin
            if (wr) begin
                mD = di; mFa = dfe;
            end else if (mPend) begin
                mD = shD; mFa = shFa;
            end
        end
        if (wr) begin
            shD = di; shFa = dfe;
        end
        mPend = wr ? !ap : (mPend && !ap);
    endtask

    task automatic checkOutput();
        checkVal("s_tick", 32'(s_tick), 32'(expS));
        checkVal("bit_tick", 32'(bit_tick), 32'(expB));
        checkVal("div_pending", 32'(div_pending), 32'(mPend));
    endtask

    task automatic applyStimulus(input bit e, input bit sr, input bit wr, input int di, input int df);
        en = e;
        sync_restart = sr;
        div_wr = wr;
        div_int = TN'(di);
        div_frac = TF'(df);
        modelStep(e, sr, wr, di, df);
        @(posedge clk);
        #1;
        checkOutput();
        if (s_tick === 1'b1) sCnt++;
        if (bit_tick === 1'b1) bCnt++;
    endtask

    task automatic runCycles(input int n, input bit e);
        for (int i = 0; i < n; i++) applyStimulus(e, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic doReset();
        reset = 1'b1; en = 1'b0; sync_restart = 1'b0; div_wr = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
        checkVal("rst_s_tick", 32'(s_tick), 32'd0);
        checkVal("rst_bit_tick", 32'(bit_tick), 32'd0);
        checkVal("rst_div_pending", 32'(div_pending), 32'd0);
    endtask

    initial begin
        $display("[TB] start");

        // fixed divisor 4, OVS 4
        doReset();
        sCnt = 0; bCnt = 0;
        runCycles(40, 1'b1);
        checkVal("fixed_sticks", 32'(sCnt), 32'd10);
        checkVal("fixed_bitticks", 32'(bCnt), 32'd2);

        // fractional divisor 4 + 8/16
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 4, 8);
        sCnt = 0;
        runCycles(147, 1'b1);
        checkVal("frac_ticks_147", 32'(sCnt), FRAC_ON ? 32'd32 : 32'd36);
        runCycles(1, 1'b1);
        checkVal("frac_ticks_148", 32'(sCnt), FRAC_ON ? 32'd33 : 32'd37);

        // reload 10 -> 3 mid-period
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 10, 0);
        runCycles(2, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 3, 0);
        checkVal("reload_pending", 32'(div_pending), 32'd1);
        sCnt = 0;
        runCycles(7, 1'b1);
        checkVal("reload_first_wrap", 32'(sCnt), 32'd1);
        checkVal("reload_pending_clr", 32'(div_pending), 32'd0);
        sCnt = 0;
        runCycles(9, 1'b1);
        checkVal("reload_new_ticks", 32'(sCnt), 32'd3);

        // sync_restart at cnt 5, ovs 2 with D = 8
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 8, 0);
        runCycles(21, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 0, 0);
        checkVal("restart_no_tick", 32'(s_tick), 32'd0);
        sCnt = 0; bCnt = 0;
        runCycles(7, 1'b1);
        checkVal("restart_quiet", 32'(sCnt), 32'd0);
        runCycles(1, 1'b1);
        checkVal("restart_tick", 32'(s_tick), 32'd1);
        runCycles(24, 1'b1);
        checkVal("restart_bittick", 32'(bCnt), 32'd1);
        checkVal("restart_bit_now", 32'(bit_tick), 32'd1);

        // en low for 7 cycles mid-period
        runCycles(3, 1'b1);
        sCnt = 0;
        runCycles(7, 1'b0);
        runCycles(4, 1'b1);
        checkVal("hold_quiet", 32'(sCnt), 32'd0);
        runCycles(1, 1'b1);
        checkVal("hold_resume_tick", 32'(s_tick), 32'd1);

        // D = 0 stops, then a write of 5 restarts
        applyStimulus(1'b0, 1'b0, 1'b1, 0, 0);
        sCnt = 0;
        runCycles(10, 1'b1);
        checkVal("stop_quiet", 32'(sCnt), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 5, 0);
        checkVal("stop_wr_applied", 32'(div_pending), 32'd0);
        runCycles(4, 1'b1);
        runCycles(1, 1'b1);
        checkVal("stop_first_tick", 32'(sCnt), 32'd1);

        // D = 1 ticks every cycle
        applyStimulus(1'b0, 1'b0, 1'b1, 1, 0);
        sCnt = 0; bCnt = 0;
        runCycles(8, 1'b1);
        checkVal("div1_sticks", 32'(sCnt), 32'd8);
        checkVal("div1_bitticks", 32'(bCnt), 32'd2);

        // reset while a shadow value is pending
        doReset();
        runCycles(2, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 9, 0);
        checkVal("rstpend_pending", 32'(div_pending), 32'd1);
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
        sCnt = 0;
        runCycles(3, 1'b1);
        checkVal("rstpend_quiet", 32'(sCnt), 32'd0);
        runCycles(1, 1'b1);
        checkVal("rstpend_def_tick", 32'(s_tick), 32'd1);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rE  = ($urandom_range(0, 15) != 0) || mPend;
            rSr = ($urandom_range(0, 39) == 0);
            rWr = rE && ($urandom_range(0, 19) == 0);
            rDi = $urandom_range(0, 12);
            rDf = $urandom_range(0, 15);
            applyStimulus(rE, rSr, rWr, rDi, rDf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

endmodule

// File: doc/baud_tick_gen.md
# baud_tick_gen

Runtime-programmable baud tick generator, successor to the fixed-divisor generator in the UART datapath. It divides `clk` by a software-written integer divisor, optionally with a fractional part, to produce the oversampling tick `s_tick` consumed by the UART RX/TX FSMs. It also produces a per-bit tick `bit_tick` every `OVS` oversample ticks. The divisor is reloaded glitch-free at a period boundary, and a receiver-driven `sync_restart` realigns the phase on start-bit detection.

## Interface
- `N`, 16: divisor integer width.
- `F`, 4: divisor fraction width (fraction = `div_frac`/2^F).
- `OVS`, 16: oversample ticks per bit, ≥2.
- `DEF_DIV`, 163: integer divisor after reset.
- `DEF_FRAC`, 0: fractional divisor after reset.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `en` in 1: count enable.
- `div_int` in N: new integer divisor.
- `div_frac` in F: new fractional divisor.
- `div_wr` in 1: one-cycle strobe; captures `div_int`/`div_frac` into the shadow registers.
- `div_pending` out 1: shadow value captured but not yet active.
- `sync_restart` in 1: synchronous phase restart.
- `s_tick` out 1: registered one-cycle oversample tick.
- `bit_tick` out 1: registered one-cycle bit tick, coincident with every `OVS`-th `s_tick`.

## Operation
- State:
  - active divisor `D`/`Fa`
  - shadow divisor
  - period counter `cnt` (N bits)
  - fraction accumulator `acc` (F bits)
  - extend flag `ext`
  - oversample counter `ovs_cnt` (ceil log2 `OVS` bits)
  - `div_pending`
- Reset:
  - `cnt`, `acc`, `ext`, `ovs_cnt` = 0.
  - `s_tick`, `bit_tick`, `div_pending` = 0.
  - Active and shadow divisor = `DEF_DIV`/`DEF_FRAC`.
- Priority: `reset` > `sync_restart` > `en`.
- Period length is `P` = `D` + `ext`. On each clock edge with `en`=1 and `D`≠0:
  - If `cnt` = `P`−1 (wrap):
    - `cnt`←0, `s_tick`←1.
    - {carry,`acc`} ← `acc` + `Fa`; `ext`←carry.
    - `ovs_cnt` advances modulo `OVS`.
    - `bit_tick`←1 iff `ovs_cnt` was `OVS`−1.
    - A pending shadow value becomes active; `div_pending`←0.
  - Otherwise: `cnt`←`cnt`+1, `s_tick`←0, `bit_tick`←0.
- `en`=0: all counters hold; `s_tick`=`bit_tick`=0. Any pending divisor is applied at that edge and `div_pending`←0.
- `D`=0 means stopped:
  - No ticks; `cnt` held at 0.
  - A pending divisor is applied at the next edge.
- `div_wr`:
  - Shadow is loaded and `div_pending`←1.
  - If applied at the same edge (wrap, `en`=0, `D`=0, or `sync_restart`), `div_pending` stays 0.
  - A second `div_wr` while pending overwrites the shadow (last write wins).
- `sync_restart`:
  - `cnt`, `acc`, `ext`, `ovs_cnt` ← 0; `s_tick`, `bit_tick` ← 0.
  - A pending divisor is applied.
  - Next period starts from a full `D`.
- Wrap compare uses N+1-bit arithmetic so `D`=2^N−1 with `ext`=1 does not overflow.

## Timing
- `s_tick`/`bit_tick` are registered: high for exactly one cycle, on the edge where `cnt` wraps.
- With `en` held high from the first edge after reset release, the first `s_tick` appears after the `D`-th edge. After that, one tick every `P` cycles.
- `D`=1, `Fa`=0: `s_tick` is high continuously.
- Divisor change latency:
  - The current period always completes at its old length.
  - The new value governs the period starting after the next wrap.
- `sync_restart` at edge k: next `s_tick` after edge k+`D`.
- Average tick period is `D` + `Fa`/2^F cycles. Instantaneous jitter is at most 1 cycle.

## Configuration
- `BAUD_FRAC_EN` defined: the fractional accumulator is as described.
- `BAUD_FRAC_EN` undefined:
  - `acc`/`ext` are not built; `ext` is 0 and `P`=`D` exactly.
  - The `div_frac` port and `F` remain but are ignored.
  - The `div_frac` shadow is not stored.

## Test plan
- Fixed divisor: `DEF_DIV`=4, `OVS`=4, `en`=1 after reset → `s_tick` after edges 4, 8, 12…; `bit_tick` with every 4th `s_tick` (edges 16, 32…).
- Fractional (`BAUD_FRAC_EN`): `div_int`=4, `div_frac`=8, `F`=4 → periods 4, 4, 5, 4, 5…; 33 ticks occur at cumulative cycle 4+4.5×32=148.
- Reload: `D`=10, `div_wr` `div_int`=3 at `cnt`=2 → `div_pending`=1 until the wrap at cycle 10; next ticks every 3 cycles.
- Restart: `D`=8, `sync_restart` at `cnt`=5 and `ovs_cnt`=2 → no tick that cycle; next `s_tick` 8 edges later; `ovs_cnt` restarts at 0.
- Hold/stop:
  - `en`=0 for 7 cycles mid-period → no ticks; period resumes with remaining count.
  - `D`=0 → no ticks; `div_wr` 5 → first `s_tick` after 5 more edges.
- Reset mid-period with `div_pending`=1 → all outputs 0; `DEF_DIV` active; shadow discarded.
